// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS generator/checker: mode codes, lengths, taps, lock FSM states.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package prbs_pkg;

  localparam logic [1:0] PRBS7  = 2'd0;
  localparam logic [1:0] PRBS15 = 2'd1;
  localparam logic [1:0] PRBS23 = 2'd2;
  localparam logic [1:0] PRBS31 = 2'd3;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  // Register length (LEN) of the active polynomial
  function automatic logic [4:0] prbs_len(input logic [1:0] mode);
    case (mode)
      PRBS7:   return 5'd7;
      PRBS15:  return 5'd15;
      PRBS23:  return 5'd23;
      default: return 5'd31;
    endcase
  endfunction

  // Upper feedback tap (always LEN-1)
  function automatic logic [4:0] tap_a(input logic [1:0] mode);
    case (mode)
      PRBS7:   return 5'd6;
      PRBS15:  return 5'd14;
      PRBS23:  return 5'd22;
      default: return 5'd30;
    endcase
  endfunction

  // Lower feedback tap
  function automatic logic [4:0] tap_b(input logic [1:0] mode);
    case (mode)
      PRBS7:   return 5'd5;
      PRBS15:  return 5'd13;
      PRBS23:  return 5'd17;
      default: return 5'd27;
    endcase
  endfunction

  // Seed restricted to the low LEN bits; an all-zero slice would lock the LFSR, so use 1
  function automatic logic [30:0] seed_for(input logic [30:0] seed, input logic [1:0] mode);
    logic [30:0] mask;
    mask = (31'd1 << prbs_len(mode)) - 31'd1;
    if ((seed & mask) == 31'd0) return 31'd1;
    return seed & mask;
  endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// Mode-selectable 31-bit shift register with reload; exposes predicted feedback bit and bit LEN-1.
// Latency: state updates one cycle after step/reload; pred/msb are combinational from state.
// Backpressure: none; holds state when step is low.
module prbs_lfsr
  import prbs_pkg::*;
#(
  parameter logic [30:0] RST_VAL = 31'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  mode,
  input  logic        step,
  input  logic        reload,
  input  logic [30:0] reload_val,
  input  logic        shift_in,
  output logic        pred,
  output logic        msb
);

  logic [30:0] sr;

  assign pred = sr[tap_a(mode)] ^ sr[tap_b(mode)];
  assign msb  = sr[prbs_len(mode) - 5'd1];

  // Reload wins over a step; bits above LEN-1 shift along as don't-care
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= RST_VAL;
    end else if (reload) begin
      sr <= reload_val;
    end else if (step) begin
      sr <= {sr[29:0], shift_in};
    end
  end

endmodule

// File: rtl/prbs_gen_chk.sv
// PRBS7/15/23/31 generator plus self-synchronising checker with lock FSM and saturating error count.
// Latency: gen_en -> gen_bit 1 cycle; chk_valid -> err_pulse/err_cnt 1 cycle.
// Backpressure: none; gen_en/chk_valid low simply freeze generator/checker. Optional PRBS_ERR_INJ_EN adds inj_err.
module prbs_gen_chk
  import prbs_pkg::*;
#(
  parameter int          ERR_W    = 16,
  parameter int          LOCK_CNT = 32,
  parameter int          LOSS_CNT = 4,
  parameter logic [30:0] SEED     = 31'd1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             gen_en,
  output logic             gen_bit,
  input  logic             chk_valid,
  input  logic             chk_bit,
  input  logic             clr_err,
`ifdef PRBS_ERR_INJ_EN
  input  logic             inj_err,
`endif
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(LOSS_CNT + 1);
  localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_CNT - 1);
  localparam logic [BW-1:0] LOSS_LAST = BW'(LOSS_CNT - 1);
  // mode_q resets to PRBS7, so the power-up value only needs a non-zero PRBS7 slice
  localparam logic [30:0] GEN_RST = (SEED[6:0] == 7'd0) ? (SEED | 31'd1) : SEED;

  logic [1:0]    mode_q;
  logic          mode_chg;
  logic [4:0]    len_q;
  logic          gen_pred, gen_msb;
  logic          chk_pred, chk_msb_unused;
  lock_state_t   state;
  logic [4:0]    fill;
  logic [MW-1:0] match;
  logic [BW-1:0] bad;
  logic          cmp, mis;

  assign mode_chg = (mode != mode_q);
  assign len_q    = prbs_len(mode_q);
  assign cmp      = chk_valid && !mode_chg && (fill == len_q);
  assign mis      = chk_bit ^ chk_pred;
  assign locked   = (state == LOCKED);

  prbs_lfsr #(.RST_VAL(GEN_RST)) u_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode_q),
    .step       (gen_en && !mode_chg),
    .reload     (mode_chg),
    .reload_val (seed_for(SEED, mode)),
    .shift_in   (gen_pred),
    .pred       (gen_pred),
    .msb        (gen_msb)
  );

  prbs_lfsr #(.RST_VAL(31'd0)) u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode_q),
    .step       (chk_valid && !mode_chg),
    .reload     (mode_chg),
    .reload_val (31'd0),
    .shift_in   (chk_bit),
    .pred       (chk_pred),
    .msb        (chk_msb_unused)
  );

  // Track the mode so a change can be seen and acted on for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mode_q <= PRBS7;
    else        mode_q <= mode;
  end

  // Emit bit LEN-1 as it stands before the shift; optional inversion leaves the LFSR untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_bit <= 1'b0;
    end else if (gen_en && !mode_chg) begin
`ifdef PRBS_ERR_INJ_EN
      gen_bit <= gen_msb ^ inj_err;
`else
      gen_bit <= gen_msb;
`endif
    end
  end

  // Lock FSM: fill, then count matches to lock; count bad bits to lose lock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEARCH;
      fill      <= 5'd0;
      match     <= '0;
      bad       <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (mode_chg) begin
        state <= SEARCH;
        fill  <= 5'd0;
        match <= '0;
        bad   <= '0;
      end else if (chk_valid) begin
        if (fill != len_q) begin
          fill <= fill + 5'd1;
        end else begin
          case (state)
            SEARCH: begin
              if (mis) begin
                match <= '0;
              end else if (match == LOCK_LAST) begin
                state <= LOCKED;
                match <= '0;
                bad   <= '0;
              end else begin
                match <= match + MW'(1);
              end
            end
            default: begin
              if (mis) begin
                err_pulse <= 1'b1;
                match     <= '0;
                if (bad == LOSS_LAST) begin
                  state <= SEARCH;
                  fill  <= 5'd0;
                  bad   <= '0;
                end else begin
                  bad <= bad + BW'(1);
                end
              end else if (match == LOCK_LAST) begin
                match <= '0;
                bad   <= '0;
              end else begin
                match <= match + MW'(1);
              end
            end
          endcase
        end
      end
    end
  end

  // Saturating error count of LOCKED mismatches; clear takes priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (clr_err) begin
      err_cnt <= '0;
    end else if (cmp && mis && (state == LOCKED) && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Directed bench for prbs_gen_chk: sequence, lock, error, saturation, loss and mode-change scenarios.
// Loopback gen_bit -> chk_bit with an optional per-bit flip; inputs change 1ns after posedge.
// Error counter built 4 bits wide so saturation is reachable.
`timescale 1ns/1ps
module tb_prbs_gen_chk;

  logic       clk = 1'b0;
  logic       rst_n, gen_en, gen_bit, chk_valid, chk_bit, clr_err;
  logic       locked, err_pulse;
  logic [1:0] mode;
  logic [3:0] err_cnt;
  logic       loop, flip, ext_bit;
`ifdef PRBS_ERR_INJ_EN
  logic       inj_err;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  int   pulses  = 0;
  logic lock_dropped = 1'b0;
  logic seq [254];

  always #5 clk = ~clk;

  assign chk_bit = loop ? (gen_bit ^ flip) : ext_bit;

  prbs_gen_chk #(.ERR_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .gen_en    (gen_en),
    .gen_bit   (gen_bit),
    .chk_valid (chk_valid),
    .chk_bit   (chk_bit),
    .clr_err   (clr_err),
`ifdef PRBS_ERR_INJ_EN
    .inj_err   (inj_err),
`endif
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input logic g, input logic v);
    gen_en    = g;
    chk_valid = v;
    @(posedge clk);
    #1;
    if (err_pulse) pulses++;
    if (!locked) lock_dropped = 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b1);
  endtask

  initial begin
    int   diffs, ones, steps;
    logic [6:0] first7;
    int   exp_sat [5] = '{6, 9, 12, 15, 15};

    rst_n = 1'b0; mode = 2'd0; gen_en = 1'b0; chk_valid = 1'b0; clr_err = 1'b0;
    loop = 1'b1; flip = 1'b0; ext_bit = 1'b0;
`ifdef PRBS_ERR_INJ_EN
    inj_err = 1'b0;
`endif
    #23;
    check_eq("rst_gen_bit", int'(gen_bit), 0);
    check_eq("rst_locked", int'(locked), 0);
    check_eq("rst_err_pulse", int'(err_pulse), 0);
    check_eq("rst_err_cnt", int'(err_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);

    // PRBS7 sequence start, period and balance
    for (int i = 0; i < 254; i++) begin
      tick(1'b1, 1'b0);
      seq[i] = gen_bit;
    end
    first7 = {seq[0], seq[1], seq[2], seq[3], seq[4], seq[5], seq[6]};
    check_eq("prbs7_first7", int'(first7), 1);
    diffs = 0;
    ones  = 0;
    for (int i = 0; i < 127; i++) begin
      if (seq[i] != seq[i+127]) diffs++;
      if (seq[i]) ones++;
    end
    check_eq("prbs7_period", diffs, 0);
    check_eq("prbs7_ones", ones, 64);

    // PRBS31 loopback lock after 31+32 valid bits
    mode = 2'd3;
    tick(1'b0, 1'b0);
    check_eq("p31_chg_locked", int'(locked), 0);
    tick(1'b1, 1'b0);
    run(62);
    check_eq("p31_lock_62", int'(locked), 0);
    run(1);
    check_eq("p31_lock_63", int'(locked), 1);
    lock_dropped = 1'b0;
    run(10000);
    check_eq("p31_clean_err", int'(err_cnt), 0);
    check_eq("p31_clean_drop", int'(lock_dropped), 0);

    // Single inverted received bit -> three mismatches
    pulses = 0;
    flip = 1'b1; tick(1'b1, 1'b1); flip = 1'b0;
    run(100);
    check_eq("flip_err_cnt", int'(err_cnt), 3);
    check_eq("flip_pulses", pulses, 3);
    check_eq("flip_locked", int'(lock_dropped), 0);

    // Saturation at 15
    for (int k = 0; k < 5; k++) begin
      flip = 1'b1; tick(1'b1, 1'b1); flip = 1'b0;
      run(100);
      check_eq($sformatf("sat_%0d", k), int'(err_cnt), exp_sat[k]);
    end
    check_eq("sat_locked", int'(lock_dropped), 0);

    // clr_err beats the increment of a simultaneous mismatch
    flip = 1'b1; clr_err = 1'b1; tick(1'b1, 1'b1); flip = 1'b0; clr_err = 1'b0;
    check_eq("clr_prio_cnt", int'(err_cnt), 0);
    check_eq("clr_prio_pulse", int'(err_pulse), 1);
    run(100);
    check_eq("clr_after", int'(err_cnt), 2);

    // Constant-1 stream: lose lock after 4 errors, count frozen in SEARCH
    pulses = 0;
    loop = 1'b0; ext_bit = 1'b1;
    steps = 0;
    while (locked && steps < 64) begin
      run(1);
      steps++;
    end
    check_eq("loss_locked", int'(locked), 0);
    check_eq("loss_err_cnt", int'(err_cnt), 6);
    run(200);
    check_eq("search_frozen", int'(err_cnt), 6);
    check_eq("search_pulses", pulses, 4);
    check_eq("search_unlocked", int'(locked), 0);

    // Lock on PRBS15, then switch to PRBS23 and re-lock after 23+32 bits
    loop = 1'b1;
    mode = 2'd1;
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    run(47);
    check_eq("p15_locked", int'(locked), 1);
    run(20);
    mode = 2'd2;
    tick(1'b0, 1'b0);
    check_eq("p23_chg_unlock", int'(locked), 0);
    tick(1'b1, 1'b0);
    run(54);
    check_eq("p23_lock_54", int'(locked), 0);
    run(1);
    check_eq("p23_lock_55", int'(locked), 1);
    check_eq("p23_err_kept", int'(err_cnt), 6);

`ifdef PRBS_ERR_INJ_EN
    run(100);
    inj_err = 1'b1; tick(1'b1, 1'b1); inj_err = 1'b0;
    run(100);
    check_eq("inj_err_cnt", int'(err_cnt), 9);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
